// File: rtl/hazard_scoreboard_pkg.sv
// Shared flag bit positions, WISC branch condition codes and the table of
// flags each condition depends on.
package hazard_scoreboard_pkg;

    localparam int NFLAG  = 3;
    localparam int FLAG_N = 0;
    localparam int FLAG_V = 1;
    localparam int FLAG_Z = 2;

    typedef enum logic [2:0] {
        COND_NEQ    = 3'b000,
        COND_EQ     = 3'b001,
        COND_GT     = 3'b010,
        COND_LT     = 3'b011,
        COND_GTE    = 3'b100,
        COND_LTE    = 3'b101,
        COND_OVFL   = 3'b110,
        COND_UNCOND = 3'b111
    } cond_e;

    // Indexed by condition code; bit positions follow FLAG_Z/V/N above.
    localparam logic [7:0][NFLAG-1:0] REQ_FLAGS = {
        3'b000,  // 111 unconditional
        3'b010,  // 110 V
        3'b101,  // 101 Z,N
        3'b101,  // 100 Z,N
        3'b001,  // 011 N
        3'b101,  // 010 Z,N
        3'b100,  // 001 Z
        3'b100   // 000 Z
    };

    function automatic logic [NFLAG-1:0] req_flags(input logic [2:0] cond);
        return REQ_FLAGS[cond];
    endfunction

endpackage

// File: rtl/sb_counter.sv
// Saturating down-counter that reloads with the larger of its decremented
// value and the requested latency; busy while non-zero.
module sb_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             busy
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] dec;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        dec   = (cnt_q == '0) ? '0 : cnt_q - CNT_W'(1);
        cnt_d = dec;
        if (load && (load_val > dec)) begin
            cnt_d = load_val;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy = (cnt_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Producer-side hazard scoreboard: records result latency at issue, counts it
// down, and stalls the front end while an ID source or branch flag is not ready.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NREG         = 16,
    parameter int CNT_W        = 2,
    parameter int ALU_FWD_LAT  = 0,
    parameter int LOAD_FWD_LAT = 1,
    parameter int WB_LAT       = 2,
    parameter int FLAG_LAT     = 1,
    parameter int PERF_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iss_valid,
    input  logic              iss_reg_write,
    input  logic              iss_mem_read,
    input  logic [3:0]        iss_rd,
    input  logic [2:0]        iss_flag_en,
    input  logic [3:0]        q_rs,
    input  logic [3:0]        q_rt,
    input  logic              q_rs_used,
    input  logic              q_rt_used,
    input  logic              q_rs_in_id,
    input  logic              q_branch,
    input  logic [2:0]        q_cond,
    output logic              stall,
    output logic              pc_wen,
    output logic              if_id_wen,
    output logic              id_ex_bubble,
    output logic [PERF_W-1:0] stall_count
);

    logic             eff;
    logic             rd_write;
    logic [CNT_W-1:0] fwd_lat;
    logic [NREG-1:0]  fwd_busy;
    logic [NREG-1:0]  wb_busy;
    logic [NFLAG-1:0] flag_busy;
    logic             rs_hazard;
    logic             rt_hazard;
    logic             flag_hazard;
    logic [PERF_W-1:0] stall_count_q;
    logic [PERF_W-1:0] stall_count_d;

    assign eff      = iss_valid & ~stall;
    assign rd_write = eff & iss_reg_write;
    assign fwd_lat  = iss_mem_read ? CNT_W'(LOAD_FWD_LAT) : CNT_W'(ALU_FWD_LAT);

    // R0 is hardwired zero, so it never has a pending write.
    assign fwd_busy[0] = 1'b0;
    assign wb_busy[0]  = 1'b0;

    for (genvar r = 1; r < NREG; r++) begin : g_reg
        sb_counter #(.CNT_W(CNT_W)) u_fwd (
            .clk      (clk),
            .rst      (rst),
            .load     (rd_write && (iss_rd == 4'(r))),
            .load_val (fwd_lat),
            .busy     (fwd_busy[r])
        );
        sb_counter #(.CNT_W(CNT_W)) u_wb (
            .clk      (clk),
            .rst      (rst),
            .load     (rd_write && (iss_rd == 4'(r))),
            .load_val (CNT_W'(WB_LAT)),
            .busy     (wb_busy[r])
        );
    end

    for (genvar f = 0; f < NFLAG; f++) begin : g_flag
        sb_counter #(.CNT_W(CNT_W)) u_flag (
            .clk      (clk),
            .rst      (rst),
            .load     (eff & iss_flag_en[f]),
            .load_val (CNT_W'(FLAG_LAT)),
            .busy     (flag_busy[f])
        );
    end

    // A BR reads rs straight from the regfile, so only writeback makes it ready.
    always_comb begin
        rs_hazard   = q_rs_used & (q_rs_in_id ? wb_busy[q_rs] : fwd_busy[q_rs]);
        rt_hazard   = q_rt_used & fwd_busy[q_rt];
        flag_hazard = q_branch & (|(req_flags(q_cond) & flag_busy));
        stall       = rst & (rs_hazard | rt_hazard | flag_hazard);
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign pc_wen       = ~stall;
    assign if_id_wen    = ~stall;
    assign id_ex_bubble = stall;
    assign stall_count  = rst ? stall_count_q : '0;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed and random checks of hazard_scoreboard against a ready-time model.
module tb_hazard_scoreboard;
    import hazard_scoreboard_pkg::*;

    localparam int ALU_FWD_LAT  = 0;
    localparam int LOAD_FWD_LAT = 1;
    localparam int WB_LAT       = 2;
    localparam int FLAG_LAT     = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        iss_valid, iss_reg_write, iss_mem_read;
    logic [3:0]  iss_rd;
    logic [2:0]  iss_flag_en;
    logic [3:0]  q_rs, q_rt;
    logic        q_rs_used, q_rt_used, q_rs_in_id, q_branch;
    logic [2:0]  q_cond;
    logic        stall, pc_wen, if_id_wen, id_ex_bubble;
    logic [15:0] stall_count;

    int checks = 0;
    int errors = 0;

    // Model: absolute cycle at which each value becomes ready.
    int          cyc = 0;
    int          fwd_rdy[16];
    int          wb_rdy[16];
    int          flg_rdy[3];
    logic [15:0] m_cnt = '0;

    hazard_scoreboard dut (
        .clk(clk), .rst(rst),
        .iss_valid(iss_valid), .iss_reg_write(iss_reg_write),
        .iss_mem_read(iss_mem_read), .iss_rd(iss_rd), .iss_flag_en(iss_flag_en),
        .q_rs(q_rs), .q_rt(q_rt), .q_rs_used(q_rs_used), .q_rt_used(q_rt_used),
        .q_rs_in_id(q_rs_in_id), .q_branch(q_branch), .q_cond(q_cond),
        .stall(stall), .pc_wen(pc_wen), .if_id_wen(if_id_wen),
        .id_ex_bubble(id_ex_bubble), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s cycle %0d got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [2:0] model_req(input logic [2:0] cond);
        logic [2:0] m = '0;
        case (cond)
            3'b000, 3'b001: m[FLAG_Z] = 1'b1;
            3'b010, 3'b100, 3'b101: begin m[FLAG_Z] = 1'b1; m[FLAG_N] = 1'b1; end
            3'b011: m[FLAG_N] = 1'b1;
            3'b110: m[FLAG_V] = 1'b1;
            default: m = '0;
        endcase
        return m;
    endfunction

    function automatic bit model_stall();
        bit s = 1'b0;
        logic [2:0] req;
        if (!rst) return 1'b0;
        if (q_rs_used) s |= q_rs_in_id ? (wb_rdy[q_rs] > cyc) : (fwd_rdy[q_rs] > cyc);
        if (q_rt_used) s |= (fwd_rdy[q_rt] > cyc);
        if (q_branch) begin
            req = model_req(q_cond);
            for (int f = 0; f < 3; f++) if (req[f] && flg_rdy[f] > cyc) s = 1'b1;
        end
        return s;
    endfunction

    // One cycle: compare outputs mid-cycle, advance the model, cross the edge.
    task automatic tick(input int want);
        bit es;
        logic [15:0] ec;
        int lat;
        @(negedge clk);
        es = model_stall();
        ec = rst ? m_cnt : 16'h0;
        check("stall", stall, es);
        check("pc_wen", pc_wen, !es);
        check("if_id_wen", if_id_wen, !es);
        check("id_ex_bubble", id_ex_bubble, es);
        check("stall_count", stall_count, ec);
        if (want >= 0) check("directed_stall", stall, (want != 0));
        if (!rst) begin
            for (int r = 0; r < 16; r++) begin fwd_rdy[r] = 0; wb_rdy[r] = 0; end
            for (int f = 0; f < 3; f++) flg_rdy[f] = 0;
            m_cnt = '0;
        end else begin
            if (iss_valid && !es) begin
                if (iss_reg_write && iss_rd != 0) begin
                    lat = iss_mem_read ? LOAD_FWD_LAT : ALU_FWD_LAT;
                    if (cyc + 1 + lat > fwd_rdy[iss_rd]) fwd_rdy[iss_rd] = cyc + 1 + lat;
                    if (cyc + 1 + WB_LAT > wb_rdy[iss_rd]) wb_rdy[iss_rd] = cyc + 1 + WB_LAT;
                end
                for (int f = 0; f < 3; f++) if (iss_flag_en[f]) flg_rdy[f] = cyc + 1 + FLAG_LAT;
            end
            if (es && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic iss(input logic v, input logic rw, input logic mr, input logic [3:0] rd,
                       input logic [2:0] fl);
        iss_valid = v; iss_reg_write = rw; iss_mem_read = mr; iss_rd = rd; iss_flag_en = fl;
    endtask

    task automatic qry(input logic [3:0] rs, input logic ru, input logic [3:0] rt, input logic tu,
                       input logic in_id, input logic br, input logic [2:0] cond);
        q_rs = rs; q_rs_used = ru; q_rt = rt; q_rt_used = tu;
        q_rs_in_id = in_id; q_branch = br; q_cond = cond;
    endtask

    task automatic idle();
        iss(0, 0, 0, 0, 0);
        qry(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        for (int r = 0; r < 16; r++) begin fwd_rdy[r] = 0; wb_rdy[r] = 0; end
        for (int f = 0; f < 3; f++) flg_rdy[f] = 0;
        rst = 1'b0;
        idle();
        @(posedge clk); #1;
        tick(0);
        tick(0);
        rst = 1'b1;

        // Load-use: LW R3, then ADD R4,R3,R5 stalls once.
        iss(1, 1, 1, 3, 0); qry(0, 0, 0, 0, 0, 0, 0); tick(0);
        iss(1, 1, 0, 4, 0); qry(3, 1, 5, 1, 0, 0, 0); tick(1);
        tick(0);
        check("load_use_count", stall_count, 16'd1);
        idle(); tick(0); tick(0);

        // ALU-use: forwarding covers it.
        iss(1, 1, 0, 3, 0); tick(0);
        iss(1, 1, 0, 6, 0); qry(3, 1, 0, 0, 0, 0, 0); tick(0);
        idle(); tick(0); tick(0);

        // BR on rs after ADD R7 waits for writeback.
        iss(1, 1, 0, 7, 0); tick(0);
        iss(1, 0, 0, 0, 0); qry(7, 1, 0, 0, 1, 1, COND_UNCOND); tick(1);
        tick(1);
        tick(0);
        idle(); tick(0); tick(0);

        // Flag hazards.
        iss(1, 1, 0, 8, 3'b111); tick(0);
        iss(1, 0, 0, 0, 0); qry(0, 0, 0, 0, 0, 1, COND_EQ); tick(1);
        tick(0);
        idle(); tick(0);
        iss(1, 1, 0, 8, 3'b111); tick(0);
        iss(1, 0, 0, 0, 0); qry(0, 0, 0, 0, 0, 1, COND_UNCOND); tick(0);
        idle(); tick(0);
        iss(1, 1, 0, 9, 3'b100); tick(0);
        iss(1, 0, 0, 0, 0); qry(0, 0, 0, 0, 0, 1, COND_OVFL); tick(0);
        idle(); tick(0); tick(0);

        // R0 never pending; back-to-back LW R2 / ADD R2 then use R2.
        iss(1, 1, 1, 0, 0); tick(0);
        iss(1, 1, 0, 1, 0); qry(0, 1, 0, 1, 0, 0, 0); tick(0);
        idle(); tick(0);
        iss(1, 1, 1, 2, 0); tick(0);
        iss(1, 1, 0, 2, 0); tick(0);
        iss(1, 1, 0, 5, 0); qry(2, 1, 2, 1, 0, 0, 0); tick(0);
        idle(); tick(0); tick(0);

        // Reset during a load-use stall clears everything.
        iss(1, 1, 1, 3, 0); tick(0);
        iss(1, 1, 0, 4, 0); qry(3, 1, 0, 0, 0, 0, 0); tick(1);
        rst = 1'b0; tick(0);
        rst = 1'b1;
        check("reset_count", stall_count, 16'd0);
        check("reset_pc_wen", pc_wen, 1'b1);
        tick(0);
        idle(); tick(0);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 63) != 0);
            iss($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)));
            qry(4'($urandom_range(0, 15)), $urandom_range(0, 1), 4'($urandom_range(0, 15)),
                $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                3'($urandom_range(0, 7)));
            tick(-1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
